// File: rtl/valid_ready_pkg.sv
// Shared constants and helpers for the valid/ready register pipeline.
package valid_ready_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_DEPTH     = 2;
    localparam int DEFAULT_REG_READY = 0;

    // Width of a counter that must hold 0 .. depth+reg_ready inclusive.
    function automatic int cnt_width(input int depth, input int reg_ready);
        return $clog2(depth + reg_ready + 1);
    endfunction

endpackage

// File: rtl/vr_stage.sv
// One valid/ready register slice: holds a single word and loads a new one
// whenever it is empty or its current word is being taken downstream.
module vr_stage
    import valid_ready_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             down_ready
);

    // Empty slot, or the held word leaves this cycle: either way we can load.
    assign up_ready = !valid || down_ready;

    // Slot register: reset clears everything, flush drops only the valid bit.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every stage
        // samples its neighbour's pre-edge value; blocking here would let a
        // word ripple through several stages in one clock.
        if (rst) begin
            valid <= 1'b0;
            // NOTE: the data word is reset as well because the pipe's reset
            // state promises out_data = 0; flush deliberately leaves it alone.
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (up_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/valid_ready_pipe_n.sv
// DEPTH-stage valid/ready register pipeline with optional input skid buffer,
// synchronous flush and a registered occupancy count.
module valid_ready_pipe_n
    import valid_ready_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int DEPTH     = DEFAULT_DEPTH,
    parameter  int REG_READY = DEFAULT_REG_READY,
    localparam int CNT_W     = cnt_width(DEPTH, REG_READY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    localparam logic [CNT_W-1:0] MAX_OCC = CNT_W'(DEPTH + REG_READY);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             in_xfer;
    logic             out_xfer;
    logic             s0_valid;
    logic [WIDTH-1:0] s0_data;
    logic             s0_ready;
    logic             last_valid;
    logic [WIDTH-1:0] last_data;

    // Stage chain: each stage's ready looks only at the next stage, so a full
    // pipe with out_ready high shifts every word forward each cycle.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             up_ready;
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             down_ready;

        if (i == 0) begin : g_first
            assign up_valid = s0_valid;
            assign up_data  = s0_data;
        end else begin : g_mid
            assign up_valid = g_stage[i-1].valid;
            assign up_data  = g_stage[i-1].data;
        end

        if (i == DEPTH - 1) begin : g_last
            assign down_ready = out_ready;
        end else begin : g_next
            assign down_ready = g_stage[i+1].up_ready;
        end

        vr_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .up_valid  (up_valid),
            .up_data   (up_data),
            .up_ready  (up_ready),
            .valid     (valid),
            .data      (data),
            .down_ready(down_ready)
        );
    end

    assign s0_ready   = g_stage[0].up_ready;
    assign last_valid = g_stage[DEPTH-1].valid;
    assign last_data  = g_stage[DEPTH-1].data;

    if (REG_READY != 0) begin : g_skid
        logic             skid_valid;
        logic [WIDTH-1:0] skid_data;

        // A word accepted while stage 0 is blocked parks here; it drains into
        // stage 0 before anything new is accepted, which preserves order.
        always_ff @(posedge clk) begin
            if (rst) begin
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (flush) begin
                skid_valid <= 1'b0;
            end else if (skid_valid) begin
                if (s0_ready) begin
                    skid_valid <= 1'b0;
                end
            end else if (in_xfer && !s0_ready) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end

        // Registered ready; an empty skid is bypassed so latency is unchanged.
        assign in_ready = !skid_valid && !flush;
        assign s0_valid = skid_valid || in_xfer;
        assign s0_data  = skid_valid ? skid_data : in_data;
    end else begin : g_direct
        assign in_ready = s0_ready && !flush;
        assign s0_valid = in_xfer;
        assign s0_data  = in_data;
    end

    assign in_xfer   = in_valid && in_ready;
    assign out_valid = last_valid && !flush;
    assign out_data  = last_data;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy tracks accepted minus delivered words; flush and reset zero it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + ONE;
        end else if (out_xfer && !in_xfer) begin
            occupancy <= occupancy - ONE;
        end
    end

    a_occ_max: assert property (@(posedge clk) disable iff (rst)
        occupancy <= MAX_OCC);

    a_occ_underflow: assert property (@(posedge clk) disable iff (rst)
        !(out_xfer && !in_xfer && occupancy == '0));

endmodule

// File: tb/tb_valid_ready_pipe_n.sv
// Directed and randomised checks of valid_ready_pipe_n across several
// DEPTH/REG_READY configurations driven from one shared stimulus set.
module tb_valid_ready_pipe_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // A: DEPTH=3 REG_READY=0
    logic       in_ready_a, out_valid_a;
    logic [7:0] out_data_a;
    logic [1:0] occ_a;
    // B: DEPTH=2 REG_READY=0
    logic       in_ready_b, out_valid_b;
    logic [7:0] out_data_b;
    logic [1:0] occ_b;
    // C: DEPTH=2 REG_READY=1
    logic       in_ready_c, out_valid_c;
    logic [7:0] out_data_c;
    logic [1:0] occ_c;
    // D/E: DEPTH=4 with REG_READY=0 (index 0) and REG_READY=1 (index 1)
    logic       rr_in_ready  [2];
    logic       rr_out_valid [2];
    logic [7:0] rr_out_data  [2];
    logic [2:0] rr_occ       [2];

    valid_ready_pipe_n #(.WIDTH(8), .DEPTH(3), .REG_READY(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_ready(out_ready), .occupancy(occ_a));

    valid_ready_pipe_n #(.WIDTH(8), .DEPTH(2), .REG_READY(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ready(out_ready), .occupancy(occ_b));

    valid_ready_pipe_n #(.WIDTH(8), .DEPTH(2), .REG_READY(1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_c), .out_valid(out_valid_c), .out_data(out_data_c),
        .out_ready(out_ready), .occupancy(occ_c));

    valid_ready_pipe_n #(.WIDTH(8), .DEPTH(4), .REG_READY(0)) dut_d (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready[0]), .out_valid(rr_out_valid[0]), .out_data(rr_out_data[0]),
        .out_ready(out_ready), .occupancy(rr_occ[0]));

    valid_ready_pipe_n #(.WIDTH(8), .DEPTH(4), .REG_READY(1)) dut_e (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready[1]), .out_valid(rr_out_valid[1]), .out_data(rr_out_data[1]),
        .out_ready(out_ready), .occupancy(rr_occ[1]));

    // Scoreboard state for the random run
    logic [7:0] sb [2][$];
    logic       prev_stall [2];
    logic [7:0] prev_data  [2];
    int         got [2];

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({in_ready_a, out_valid_a, out_data_a, occ_a} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
            n_fail++; $display("FAIL reset_a: got rdy=%b vld=%b data=%h occ=%0d want rdy=1 vld=0 data=00 occ=0", in_ready_a, out_valid_a, out_data_a, occ_a);
        end
        n_checks++;
        if ({in_ready_b, out_valid_b, out_data_b, occ_b} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
            n_fail++; $display("FAIL reset_b: got rdy=%b vld=%b data=%h occ=%0d want rdy=1 vld=0 data=00 occ=0", in_ready_b, out_valid_b, out_data_b, occ_b);
        end
        n_checks++;
        if ({in_ready_c, out_valid_c, out_data_c, occ_c} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
            n_fail++; $display("FAIL reset_c: got rdy=%b vld=%b data=%h occ=%0d want rdy=1 vld=0 data=00 occ=0", in_ready_c, out_valid_c, out_data_c, occ_c);
        end
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if ({rr_in_ready[j], rr_out_valid[j], rr_out_data[j], rr_occ[j]} !== {1'b1, 1'b0, 8'h00, 3'd0}) begin
                n_fail++; $display("FAIL reset_d4[%0d]: got rdy=%b vld=%b data=%h occ=%0d want rdy=1 vld=0 data=00 occ=0", j, rr_in_ready[j], rr_out_valid[j], rr_out_data[j], rr_occ[j]);
            end
        end
    endtask

    // DEPTH=3: three words in back-to-back, first appears DEPTH-1 edges after accept.
    task automatic test_latency();
        logic [7:0] w [3];
        w = '{8'h11, 8'h22, 8'h33};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = w[k];
            #1;
            n_checks++;
            if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
                n_fail++; $display("FAIL lat_fill%0d: got rdy=%b vld=%b want rdy=1 vld=0", k, in_ready_a, out_valid_a);
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== w[k] || occ_a !== 2'(3 - k)) begin
                n_fail++; $display("FAIL lat_out%0d: got vld=%b data=%h occ=%0d want vld=1 data=%h occ=%0d", k, out_valid_a, out_data_a, occ_a, w[k], 3 - k);
            end
            step();
        end
        n_checks++;
        if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin
            n_fail++; $display("FAIL lat_empty: got vld=%b occ=%0d want vld=0 occ=0", out_valid_a, occ_a);
        end
    endtask

    // DEPTH=2 full pipe: simultaneous in/out transfer keeps occupancy.
    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; in_data = 8'hA1;
        step();
        in_data = 8'hA2;
        step();
        in_data = 8'hA3;
        #1;
        n_checks++;
        if (in_ready_b !== 1'b0 || occ_b !== 2'd2 || out_valid_b !== 1'b1 || out_data_b !== 8'hA1) begin
            n_fail++; $display("FAIL b2b_full: got rdy=%b occ=%0d vld=%b data=%h want rdy=0 occ=2 vld=1 data=a1", in_ready_b, occ_b, out_valid_b, out_data_b);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready_b !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_follow: got %b want 1", in_ready_b);
        end
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++;
        if (occ_b !== 2'd2 || out_data_b !== 8'hA2) begin
            n_fail++; $display("FAIL b2b_swap: got occ=%0d data=%h want occ=2 data=a2", occ_b, out_data_b);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'hA3 || occ_b !== 2'd1) begin
            n_fail++; $display("FAIL b2b_a3: got vld=%b data=%h occ=%0d want vld=1 data=a3 occ=1", out_valid_b, out_data_b, occ_b);
        end
        step();
        n_checks++;
        if (out_valid_b !== 1'b0 || occ_b !== 2'd0) begin
            n_fail++; $display("FAIL b2b_drain: got vld=%b occ=%0d want vld=0 occ=0", out_valid_b, occ_b);
        end
    endtask

    // REG_READY=1, DEPTH=2: capacity 3, skid drains first, order preserved.
    task automatic test_skid();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'(k + 1);
            #1;
            n_checks++;
            if (in_ready_c !== (k < 3)) begin
                n_fail++; $display("FAIL skid_accept%0d: got %b want %b", k, in_ready_c, (k < 3));
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (occ_c !== 2'd3 || in_ready_c !== 1'b0 || out_valid_c !== 1'b1 || out_data_c !== 8'h01) begin
            n_fail++; $display("FAIL skid_full: got occ=%0d rdy=%b vld=%b data=%h want occ=3 rdy=0 vld=1 data=01", occ_c, in_ready_c, out_valid_c, out_data_c);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (out_valid_c !== 1'b1 || out_data_c !== 8'(k + 1) || occ_c !== 2'(3 - k)) begin
                n_fail++; $display("FAIL skid_out%0d: got vld=%b data=%h occ=%0d want vld=1 data=%0d occ=%0d", k, out_valid_c, out_data_c, occ_c, k + 1, 3 - k);
            end
            if (k == 1) begin
                n_checks++;
                if (in_ready_c !== 1'b1) begin
                    n_fail++; $display("FAIL skid_ready_rise: got %b want 1", in_ready_c);
                end
            end
            step();
        end
        n_checks++;
        if (out_valid_c !== 1'b0 || occ_c !== 2'd0) begin
            n_fail++; $display("FAIL skid_empty: got vld=%b occ=%0d want vld=0 occ=0", out_valid_c, occ_c);
        end
    endtask

    // Flush with a word on the input: nothing moves, pipe empties, later word alone.
    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 8'h01;
        step();
        in_data = 8'h02;
        step();
        flush = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready_b !== 1'b0 || out_valid_b !== 1'b0 || in_ready_c !== 1'b0) begin
            n_fail++; $display("FAIL flush_gate: got rdy_b=%b vld_b=%b rdy_c=%b want 0 0 0", in_ready_b, out_valid_b, in_ready_c);
        end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++;
        if (occ_b !== 2'd0 || out_valid_b !== 1'b0 || occ_c !== 2'd0) begin
            n_fail++; $display("FAIL flush_clear: got occ_b=%0d vld_b=%b occ_c=%0d want 0 0 0", occ_b, out_valid_b, occ_c);
        end
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid_b !== 1'b0) begin
            n_fail++; $display("FAIL flush_stale: got vld=%b data=%h want vld=0", out_valid_b, out_data_b);
        end
        step();
        n_checks++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'h5A || occ_b !== 2'd1) begin
            n_fail++; $display("FAIL flush_5a: got vld=%b data=%h occ=%0d want vld=1 data=5a occ=1", out_valid_b, out_data_b, occ_b);
        end
        step();
        n_checks++;
        if (out_valid_b !== 1'b0 || occ_b !== 2'd0) begin
            n_fail++; $display("FAIL flush_alone: got vld=%b occ=%0d want vld=0 occ=0", out_valid_b, occ_b);
        end
    endtask

    // Reset with three held words and live traffic on both sides.
    task automatic test_mid_reset();
        do_reset();
        in_valid = 1'b1; in_data = 8'h31;
        step();
        in_data = 8'h32;
        step();
        in_data = 8'h33;
        step();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (occ_a !== 2'd3 || out_data_a !== 8'h31) begin
            n_fail++; $display("FAIL rst_preload: got occ=%0d data=%h want occ=3 data=31", occ_a, out_data_a);
        end
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++;
        if (out_valid_a !== 1'b0 || out_data_a !== 8'h00 || occ_a !== 2'd0 || in_ready_a !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid: got vld=%b data=%h occ=%0d rdy=%b want vld=0 data=00 occ=0 rdy=1", out_valid_a, out_data_a, occ_a, in_ready_a);
        end
        step();
        step();
        step();
        n_checks++;
        if (out_valid_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_dropped: got vld=%b data=%h want vld=0", out_valid_a, out_data_a);
        end
    endtask

    // DEPTH=4, both REG_READY settings, random traffic against an in-order scoreboard.
    task automatic test_random();
        int cyc = 0;
        int nf  = 0;
        logic [7:0] want;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            sb[j].delete();
            prev_stall[j] = 1'b0;
            prev_data[j]  = 8'h00;
            got[j]        = 0;
        end
        while ((got[0] < 10000 || got[1] < 10000) && cyc < 60000 && nf < 20) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (int'(rr_occ[j]) !== sb[j].size()) begin
                    n_fail++; nf++; $display("FAIL rand_occ[%0d] cyc %0d: got %0d want %0d", j, cyc, rr_occ[j], sb[j].size());
                end
                if (prev_stall[j]) begin
                    n_checks++;
                    if (rr_out_valid[j] !== 1'b1 || rr_out_data[j] !== prev_data[j]) begin
                        n_fail++; nf++; $display("FAIL rand_stall[%0d] cyc %0d: got vld=%b data=%h want vld=1 data=%h", j, cyc, rr_out_valid[j], rr_out_data[j], prev_data[j]);
                    end
                end
                if (rr_out_valid[j] === 1'b1) begin
                    want = (sb[j].size() > 0) ? sb[j][0] : 8'h00;
                    n_checks++;
                    if (sb[j].size() == 0 || rr_out_data[j] !== want) begin
                        n_fail++; nf++; $display("FAIL rand_data[%0d] cyc %0d: got %h want %h (held %0d)", j, cyc, rr_out_data[j], want, sb[j].size());
                    end
                    if (out_ready && sb[j].size() > 0) begin
                        void'(sb[j].pop_front());
                        got[j]++;
                    end
                end
                if (in_valid && rr_in_ready[j] === 1'b1) begin
                    sb[j].push_back(in_data);
                end
                prev_stall[j] = (rr_out_valid[j] === 1'b1) && !out_ready;
                prev_data[j]  = rr_out_data[j];
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (got[j] < 10000) begin
                n_fail++; $display("FAIL rand_count[%0d]: got %0d words in %0d cycles want 10000", j, got[j], cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_skid();
        test_flush();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
